// File: rtl/fwd_hazard_if.sv
// ID-stage bundle between the decode stage and the forwarding/hazard controller.
// The master side drives the ID instruction fields; the slave returns bypass selects and stall state.
interface fwd_hazard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int CNT_W      = 32
) ();
    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]            id_src_used;
    logic [REG_ADDR_W-1:0]         id_dst_addr;
    logic                          id_dst_wr;
    logic                          id_is_load;
    logic                          flush;
    logic                          stall_ext;
    logic [NUM_SRC*2-1:0]          fwd_sel;
    logic                          load_stall;
    logic [CNT_W-1:0]              stall_cnt;

    modport master (
        output id_valid, id_src_addr, id_src_used, id_dst_addr, id_dst_wr, id_is_load,
        output flush, stall_ext,
        input  fwd_sel, load_stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_dst_addr, id_dst_wr, id_is_load,
        input  flush, stall_ext,
        output fwd_sel, load_stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller tracking EX/MEM/WB destinations.
// Optional macro FWD_WB_EN: when defined, WB-stage producers are forwarded (select 3).
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    fwd_hazard_if.slave  bus
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  wr;
        logic                  load;
    } stage_t;

    stage_t           ex_q, ex_d;
    stage_t           mem_q, mem_d;
    stage_t           wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC*2-1:0] fwd_sel_s;
    logic                 hazard_s;
    logic                 load_stall_s;

    function automatic logic stage_match(input stage_t s, input logic used,
                                         input logic [REG_ADDR_W-1:0] src);
        return used & s.valid & s.wr & (s.dst == src) & (src != {REG_ADDR_W{1'b0}});
    endfunction

    // Per-operand bypass select, youngest producer first, plus load-use detection.
    always_comb begin
        fwd_sel_s = '0;
        hazard_s  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (stage_match(ex_q, bus.id_src_used[i], bus.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
                fwd_sel_s[2*i +: 2] = 2'd1;
                if (ex_q.load) begin
                    hazard_s = 1'b1;
                end else begin
                    hazard_s = hazard_s;
                end
            end else if (stage_match(mem_q, bus.id_src_used[i], bus.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
                fwd_sel_s[2*i +: 2] = 2'd2;
`ifdef FWD_WB_EN
            end else if (stage_match(wb_q, bus.id_src_used[i], bus.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W])) begin
                fwd_sel_s[2*i +: 2] = 2'd3;
`endif
            end else begin
                fwd_sel_s[2*i +: 2] = 2'd0;
            end
        end
        load_stall_s = hazard_s & bus.id_valid & ~bus.flush;
    end

    // Pipeline advance and saturating stall counter; a freeze holds everything.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.stall_ext) begin
            wb_d     = mem_q;
            mem_d    = ex_q;
            ex_d.valid = bus.id_valid & ~bus.flush & ~load_stall_s;
            ex_d.dst   = bus.id_dst_addr;
            ex_d.wr    = bus.id_dst_wr;
            ex_d.load  = bus.id_is_load;
            if (load_stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fwd_sel    = fwd_sel_s;
    assign bus.load_stall = load_stall_s;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios then random traffic vs. a reference model.
module tb_fwd_hazard_unit;
    localparam int RW  = 5;
    localparam int NS  = 2;
    localparam int CW  = 6;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef FWD_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_hazard_if #(.REG_ADDR_W(RW), .NUM_SRC(NS), .CNT_W(CW)) bus ();
    fwd_hazard_unit #(.REG_ADDR_W(RW), .NUM_SRC(NS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Reference model: list of in-flight instructions, index 0 = youngest (EX).
    typedef struct {
        bit v;
        int dst;
        bit wr;
        bit ld;
    } rec_t;
    rec_t pipe [3];
    int   cnt_m;

    // Current stimulus.
    bit in_v, in_wr, in_ld, in_fl, in_se, in_rst;
    int in_src [NS];
    bit in_used [NS];
    int in_dst;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_sel(input int i);
        for (int s = 0; s < 3; s++) begin
            if (s == 2 && !WB_EN) continue;
            if (in_used[i] && pipe[s].v && pipe[s].wr && pipe[s].dst == in_src[i] && in_src[i] != 0)
                return s + 1;
        end
        return 0;
    endfunction

    task automatic set_id(input bit v, input int s0, input bit u0, input int s1, input bit u1,
                          input int d, input bit wr, input bit ld);
        in_v = v; in_src[0] = s0; in_used[0] = u0; in_src[1] = s1; in_used[1] = u1;
        in_dst = d; in_wr = wr; in_ld = ld;
        in_fl = 1'b0; in_se = 1'b0; in_rst = 1'b0;
    endtask

    // One cycle: drive, check combinational outputs, clock, advance model.
    task automatic step();
        logic [NS*2-1:0] e_sel;
        bit hz, e_ls;
        bus.id_valid = in_v;
        for (int i = 0; i < NS; i++) begin
            bus.id_src_addr[i*RW +: RW] = in_src[i][RW-1:0];
            bus.id_src_used[i] = in_used[i];
        end
        bus.id_dst_addr = in_dst[RW-1:0];
        bus.id_dst_wr   = in_wr;
        bus.id_is_load  = in_ld;
        bus.flush       = in_fl;
        bus.stall_ext   = in_se;
        rst             = in_rst;
        #1;
        hz = 1'b0;
        for (int i = 0; i < NS; i++) begin
            int s;
            s = exp_sel(i);
            e_sel[2*i +: 2] = s[1:0];
            if (s == 1 && pipe[0].ld) hz = 1'b1;
        end
        e_ls = hz && in_v && !in_fl;
        check_val("fwd_sel", bus.fwd_sel, e_sel);
        check_val("load_stall", bus.load_stall, e_ls);
        check_val("stall_cnt", bus.stall_cnt, cnt_m);
        @(posedge clk);
        if (in_rst) begin
            for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
            cnt_m = 0;
        end else if (!in_se) begin
            if (e_ls && cnt_m < CNT_MAX) cnt_m++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{in_v && !in_fl && !e_ls, in_dst, in_wr, in_ld};
        end
        @(negedge clk);
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        in_rst = 1'b1;
        rst = 1'b1;
        bus.id_valid = 0; bus.id_src_addr = '0; bus.id_src_used = '0; bus.id_dst_addr = '0;
        bus.id_dst_wr = 0; bus.id_is_load = 0; bus.flush = 0; bus.stall_ext = 0;
        @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
        cnt_m = 0;
        // Reset-state check (reset held another cycle).
        step();

        // EX forward of add r3 to operand 0.
        set_id(1, 0, 0, 0, 0, 3, 1, 0); step();
        set_id(1, 3, 1, 0, 0, 0, 0, 0); step();
        // EX beats MEM; then MEM after a non-writing instruction.
        set_id(1, 0, 0, 0, 0, 3, 1, 0); step();
        set_id(1, 0, 0, 0, 0, 3, 1, 0); step();
        set_id(1, 0, 0, 3, 1, 0, 0, 0); step();
        set_id(1, 0, 0, 3, 1, 0, 0, 0); step();
        // Load-use: stall one cycle, then MEM forward.
        set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
        set_id(1, 0, 0, 5, 1, 6, 1, 0); step();
        step();
        step();
        // Load-use killed by flush.
        set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
        set_id(1, 0, 0, 5, 1, 6, 1, 0); in_fl = 1'b1; step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); step();
        // r0 never forwarded; unused operand ignored.
        set_id(1, 0, 0, 0, 0, 0, 1, 1); step();
        set_id(1, 0, 1, 0, 1, 0, 0, 0); step();
        set_id(1, 0, 0, 0, 0, 4, 1, 1); step();
        set_id(1, 4, 0, 4, 0, 0, 0, 0); step();
        // r7 only in WB.
        set_id(1, 0, 0, 0, 0, 7, 1, 0); step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); step();
        step();
        set_id(1, 7, 1, 0, 0, 0, 0, 0); step();
        // Hazard frozen for three cycles, then released.
        set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
        set_id(1, 5, 1, 0, 0, 0, 0, 0); in_se = 1'b1;
        repeat (3) step();
        in_se = 1'b0; step();
        step();
        // Reset mid-stall.
        set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
        set_id(1, 0, 0, 5, 1, 0, 0, 0); in_rst = 1'b1; step();
        in_rst = 1'b0; step();
        // Back-to-back dependent loads drive the counter into saturation.
        set_id(1, 5, 1, 0, 0, 5, 1, 1);
        repeat (140) step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            in_v      = ($urandom_range(0, 9) != 0);
            in_src[0] = $urandom_range(0, 7);
            in_src[1] = $urandom_range(0, 7);
            in_used[0] = $urandom_range(0, 3) != 0;
            in_used[1] = $urandom_range(0, 3) != 0;
            in_dst    = $urandom_range(0, 7);
            in_wr     = $urandom_range(0, 3) != 0;
            in_ld     = $urandom_range(0, 2) == 0;
            in_fl     = $urandom_range(0, 9) == 0;
            in_se     = $urandom_range(0, 7) == 0;
            in_rst    = $urandom_range(0, 299) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard controller for the redirect pipeline. It tracks destination registers of the instructions in EX, MEM and WB internally, and drives per-operand bypass mux selects for up to NUM_SRC source operands of the instruction in ID. On a load-use hazard it stalls ID for exactly one cycle, counts those stalls, and honours branch-redirect flushes and a global pipeline freeze.

## Interface
- REG_ADDR_W, 5, register-number width
- NUM_SRC, 2, number of ID source operands (1..4)
- CNT_W, 32, stall-counter width
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src_addr  in  NUM_SRC*REG_ADDR_W  source register numbers; operand i at [i*REG_ADDR_W +: REG_ADDR_W]
- id_src_used  in  NUM_SRC  operand i is actually read
- id_dst_addr  in  REG_ADDR_W  ID destination register
- id_dst_wr  in  1  ID instruction writes id_dst_addr
- id_is_load  in  1  ID instruction is a load
- flush  in  1  redirect: ID instruction is killed, does not enter EX
- stall_ext  in  1  global freeze: all tracked stages hold
- fwd_sel  out  NUM_SRC*2  per-operand select; operand i at [2i +: 2]: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
- load_stall  out  1  hold PC/IF/ID, inject bubble into EX
- stall_cnt  out  CNT_W  number of load-use stall cycles taken

## Operation
- Three tracking stages EX, MEM, WB, each {valid, dst, wr, load}.
- Match for operand i against stage S: id_src_used[i] & S.valid & S.wr & (S.dst == src_i) & (src_i != 0).
- fwd_sel[i] (combinational): EX match -> 1; else MEM match -> 2; else WB match -> 3; else 0. Youngest producer wins.
- Hazard: any operand with an EX match where EX.load = 1. load_stall = hazard & id_valid & ~flush.
- fwd_sel is still driven during load_stall; the consumer ignores it while stalled.
- Stage update when stall_ext = 0:
  - WB <= MEM, MEM <= EX.
  - EX <= ID fields with valid = id_valid & ~flush & ~load_stall; otherwise a bubble (valid = 0).
- Stage update when stall_ext = 1: all stages hold and stall_cnt holds.
- stall_cnt increments by 1 on each edge where load_stall = 1 and stall_ext = 0. It saturates at all-ones and never wraps.
- Register 0 is never forwarded and never causes a stall.

## Timing
- fwd_sel and load_stall are combinational from the ID inputs and stage registers. They are valid in the same cycle, with zero latency.
- Load-use stall lasts exactly 1 cycle, unless stall_ext extends it. Next cycle the load is in MEM and the consumer gets fwd_sel = 2.
- flush together with a hazard: flush wins. load_stall = 0, a bubble goes to EX, and stall_cnt does not increment.
- stall_ext together with a hazard: load_stall stays asserted and the stall is not counted until the freeze releases.
- Reset (any cycle, including mid-stall): all stage valids = 0 on the next edge, so fwd_sel = 0 and load_stall = 0. stall_cnt = 0.
- Sustained back-to-back hazards each cost exactly one bubble.

## Configuration
- FWD_WB_EN defined: WB matches are forwarded (select 3).
- FWD_WB_EN undefined: WB matches are ignored and select 3 is never produced. The register file must be write-before-read. All other behaviour is identical.

## Test plan
- add r3 in EX (wr = 1); ID reads r3 on operand 0 -> fwd_sel[1:0] = 1, load_stall = 0.
- r3 written by EX and MEM; ID reads r3 on operand 1 -> fwd_sel[3:2] = 1 (EX wins). After a bubble, same read -> 2.
- lw r5 in EX; ID uses r5 on operand 1 -> load_stall = 1 for one cycle and EX becomes a bubble. Next cycle fwd_sel[3:2] = 2, load_stall = 0, stall_cnt = 1. Repeat with flush = 1 in the hazard cycle -> load_stall = 0, stall_cnt unchanged.
- EX writes r0 and ID reads r0 -> fwd_sel = 0, no stall. Operand with id_src_used = 0 and a matching EX -> sel 0.
- r7 only in WB -> with FWD_WB_EN, sel = 3; without it, sel = 0.
- Hazard held with stall_ext = 1 for 3 cycles, then released -> stall_cnt increments only once. rst asserted mid-stall -> next cycle all outputs 0. Force stall_cnt to all-ones and take another stall -> stall_cnt stays all-ones.
